// File: rtl/octal_enc_pkg.sv
// Shared widths and index type for the octal-to-binary priority encoder.
package octal_enc_pkg;

    localparam int unsigned OCT_IN_W  = 8;
    localparam int unsigned OCT_IDX_W = 3;

    typedef logic [OCT_IDX_W-1:0] oct_idx_t;

endpackage

// File: rtl/octal_binary_encoder_core.sv
// Combinational 8-to-3 priority encoder: highest set bit wins, plus
// any-bit-set and two-or-more-bits-set flags.
module octal_binary_encoder_core
    import octal_enc_pkg::*;
(
    input  logic [OCT_IN_W-1:0] in,
    output oct_idx_t            idx,
    output logic                any,
    output logic                multi
);

    logic [OCT_IN_W-1:0] w_in_minus_one;

    // Ascending scan with last-assignment-wins gives the same result as a
    // descending scan that stops at the first set bit.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < OCT_IN_W; i++) begin
            if (in[i]) begin
                idx = oct_idx_t'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_in_minus_one = in - OCT_IN_W'(1);
    assign any            = |in;
    assign multi          = |(in & w_in_minus_one);

endmodule

// File: rtl/octal_binary_encoder.sv
// Registered 8-to-3 priority encoder with one clock of latency and
// asynchronous active-low reset on the output stage.
module octal_binary_encoder
    import octal_enc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OCT_IN_W-1:0] in,
    output oct_idx_t            out,
    output logic                valid,
    output logic                multi_hot
);

    oct_idx_t w_idx;
    logic     w_any;
    logic     w_multi;

    oct_idx_t r_out;
    logic     r_valid;
    logic     r_multi_hot;

    octal_binary_encoder_core u_core (
        .in    (in),
        .idx   (w_idx),
        .any   (w_any),
        .multi (w_multi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_valid     <= 1'b0;
            r_multi_hot <= 1'b0;
        end else begin
            r_out       <= w_idx;
            r_valid     <= w_any;
            r_multi_hot <= w_multi;
        end
    end

    assign out       = r_out;
    assign valid     = r_valid;
    assign multi_hot = r_multi_hot;

endmodule

// File: tb/tb_octal_binary_encoder.sv
// Directed and exhaustive self-checking bench for octal_binary_encoder.
module tb_octal_binary_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;
    logic       multi_hot;

    int unsigned checks;
    int unsigned failures;

    octal_binary_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .out       (out),
        .valid     (valid),
        .multi_hot (multi_hot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_out,
                             input logic e_valid, input logic e_multi);
        check({tag, ".out"},       {5'd0, out},       {5'd0, e_out});
        check({tag, ".valid"},     {7'd0, valid},     {7'd0, e_valid});
        check({tag, ".multi_hot"}, {7'd0, multi_hot}, {7'd0, e_multi});
    endtask

    // Apply a value, let one rising edge capture it, sample 1 ns later.
    task automatic step(input logic [7:0] v);
        in = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ref_model(input logic [7:0] v);
        logic [2:0] idx;
        logic       found;
        idx   = 3'd0;
        found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (!found && v[k]) begin
                idx   = 3'(k);
                found = 1'b1;
            end
        end
        return {idx, (v != 8'h00), ($countones(v) >= 2)};
    endfunction

    initial begin
        logic [4:0] r;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in       = 8'h00;

        #2;
        check_all("reset", 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset_held", 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Walking one
        step(8'h00); check_all("walk_zero", 3'd0, 1'b0, 1'b0);
        step(8'h01); check_all("walk_b0", 3'd0, 1'b1, 1'b0);
        step(8'h02); check_all("walk_b1", 3'd1, 1'b1, 1'b0);
        step(8'h04); check_all("walk_b2", 3'd2, 1'b1, 1'b0);
        step(8'h08); check_all("walk_b3", 3'd3, 1'b1, 1'b0);
        step(8'h10); check_all("walk_b4", 3'd4, 1'b1, 1'b0);
        step(8'h20); check_all("walk_b5", 3'd5, 1'b1, 1'b0);
        step(8'h40); check_all("walk_b6", 3'd6, 1'b1, 1'b0);
        step(8'h80); check_all("walk_b7", 3'd7, 1'b1, 1'b0);

        // Multi-hot priority
        step(8'b1000_0001); check_all("multi_81", 3'd7, 1'b1, 1'b1);
        step(8'b0001_0110); check_all("multi_16", 3'd4, 1'b1, 1'b1);
        step(8'hFF);        check_all("multi_ff", 3'd7, 1'b1, 1'b1);
        step(8'h03);        check_all("multi_03", 3'd1, 1'b1, 1'b1);

        // Zero versus bit 0
        step(8'h00); check_all("zero", 3'd0, 1'b0, 1'b0);
        step(8'h01); check_all("bit0", 3'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        step(8'h20); check_all("pre_rst", 3'd5, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in = (i == 1) ? 8'hFF : 8'h80;
            @(posedge clk);
            #1;
            check_all("rst_low", 3'd0, 1'b0, 1'b0);
        end
        in = 8'h40;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("rst_release", 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("post_rst", 3'd6, 1'b1, 1'b0);

        // Exhaustive sweep, back-to-back
        for (int v = 0; v < 256; v++) begin
            step(8'(v));
            r = ref_model(8'(v));
            check_all("sweep", r[4:2], r[1], r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
